// File: rtl/bf_stage_io_pkg.sv
// Shared opcodes and FSM state type for the Brainfuck pipeline I/O stage.
package bf_stage_io_pkg;

  localparam int OPCODE_MSB = 3;

  localparam logic [OPCODE_MSB:0] OP_NOP   = 4'h0;
  localparam logic [OPCODE_MSB:0] OP_INC   = 4'h1;
  localparam logic [OPCODE_MSB:0] OP_DEC   = 4'h2;
  localparam logic [OPCODE_MSB:0] OP_RIGHT = 4'h3;
  localparam logic [OPCODE_MSB:0] OP_LEFT  = 4'h4;
  localparam logic [OPCODE_MSB:0] OP_OUT   = 4'h5;
  localparam logic [OPCODE_MSB:0] OP_IN    = 4'h6;
  localparam logic [OPCODE_MSB:0] OP_JZ    = 4'h7;
  localparam logic [OPCODE_MSB:0] OP_JNZ   = 4'h8;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    TX      = 2'd2,
    WAIT_IN = 2'd3
  } io_state_t;

  // 8N1 frame, shifted out LSB first: start(0), data[0..7], stop(1).
  function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/bf_stage_io_uart.sv
// 8N1 UART transmit shifter: frame register plus baud and bit counters.
module bf_uart_tx_shifter
  import bf_stage_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [CW-1:0]         baud_cnt;
  logic [3:0]            bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
    end else if (start && !busy) begin
      shreg    <= uart_frame(data);
      baud_cnt <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          busy    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

  // Idle high whenever no frame is in flight, including straight out of reset.
  assign tx = busy ? shreg[0] : 1'b1;

endmodule

// File: rtl/bf_stage_io.sv
// Brainfuck pipeline I/O stage: OUT serialises the accumulator over UART, IN captures a byte.
// Define BF_IO_ECHO_EN to retransmit each captured IN byte before handing it downstream.
module bf_stage_io
  import bf_stage_io_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int OP_WIDTH     = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] operation_in,
  input  logic [D_WIDTH-1:0]  a_in,
  input  logic                drdy_in,
  output logic                ack,
  output logic [OP_WIDTH-1:0] operation,
  output logic [D_WIDTH-1:0]  a,
  output logic                drdy,
  input  logic                ack_in,
  output logic                tx,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready
);

  // Handshake: a transfer happens on a rising clk edge where valid and ack are both
  // high on the same side (drdy_in/ack upstream, drdy/ack_in downstream, in_valid/in_ready).

  io_state_t           state, state_n;
  logic [OP_WIDTH-1:0] op_q, op_n;
  logic [D_WIDTH-1:0]  a_q, a_n;
  logic                start, busy;
  logic [7:0]          start_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      op_q  <= OP_WIDTH'(OP_NOP);
      a_q   <= '0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      a_q   <= a_n;
    end
  end

  always_comb begin
    state_n    = state;
    op_n       = op_q;
    a_n        = a_q;
    start      = 1'b0;
    start_data = a_in[7:0];
    ack        = 1'b0;
    drdy       = 1'b0;
    in_ready   = 1'b0;

    unique case (state)
      EMPTY: ack = 1'b1;
      FULL: begin
        drdy = 1'b1;
        ack  = ack_in;
        if (ack_in) begin
          state_n = EMPTY;
          op_n    = OP_WIDTH'(OP_NOP);
        end
      end
      // Leave one idle-high cycle after the stop bit before presenting downstream.
      TX: if (!busy) state_n = FULL;
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_n = D_WIDTH'(in_data);
`ifdef BF_IO_ECHO_EN
          start      = 1'b1;
          start_data = in_data;
          state_n    = TX;
`else
          state_n = FULL;
`endif
        end
      end
      default: state_n = EMPTY;
    endcase

    // Accepting upstream overrides the FULL->EMPTY drain so back-to-back ops have no bubble.
    if (drdy_in && ack) begin
      op_n = operation_in;
      a_n  = a_in;
      if (operation_in == OP_WIDTH'(OP_OUT)) begin
        start      = 1'b1;
        start_data = a_in[7:0];
        state_n    = TX;
      end else if (operation_in == OP_WIDTH'(OP_IN)) begin
        state_n = WAIT_IN;
      end else begin
        state_n = FULL;
      end
    end
  end

  assign operation = op_q;
  assign a         = a_q;

  bf_uart_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (start_data),
    .busy  (busy),
    .tx    (tx)
  );

endmodule

// File: tb/tb_bf_stage_io.sv
// Self-checking bench for bf_stage_io: directed cases plus a randomized run against a transaction model.
module tb_bf_stage_io;
  import bf_stage_io_pkg::*;

  localparam int CPB = 4;

  logic       clk, rst;
  logic [3:0] operation_in, operation;
  logic [7:0] a_in, a, in_data;
  logic       drdy_in, ack, drdy, ack_in, tx, in_valid, in_ready;

  bf_stage_io #(.D_WIDTH(8), .OP_WIDTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(rst), .operation_in(operation_in), .a_in(a_in), .drdy_in(drdy_in),
    .ack(ack), .operation(operation), .a(a), .drdy(drdy), .ack_in(ack_in), .tx(tx),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model / scoreboard ----------------
  // Model: every accepted op comes out downstream in order; OUT keeps a_in and also
  // appears on the line; IN takes the next byte of the input stream.
  logic [11:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  in_bytes[256];
  int          model_in_idx = 0;
  int          feed_idx = 0;
  int          in_hs_cnt = 0;
  int          up_cnt = 0;
  int          tx_frames = 0;
  logic        hold = 1'b0;
  logic [11:0] hold_val;
  logic [11:0] e;
  logic [7:0]  b;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (drdy_in && ack) begin
        up_cnt++;
        if (operation_in == OP_OUT) begin
          exp_q.push_back({OP_OUT, a_in});
          exp_tx_q.push_back(a_in);
        end else if (operation_in == OP_IN) begin
          b = in_bytes[model_in_idx];
          model_in_idx++;
          exp_q.push_back({OP_IN, b});
`ifdef BF_IO_ECHO_EN
          exp_tx_q.push_back(b);
`endif
        end else begin
          exp_q.push_back({operation_in, a_in});
        end
      end
      if (drdy && ack_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'({operation, a}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_item", 32'({operation, a}), 32'(e));
        end
      end
      if (drdy) check("ack_tracks_ack_in", 32'(ack), 32'(ack_in));
      if (in_ready) check("ack_low_in_wait", 32'(ack), 32'(0));
      if (hold) check("hold_stable", 32'({drdy, operation, a}), 32'({1'b1, hold_val}));
      hold = drdy && !ack_in;
      hold_val = {operation, a};
      if (in_valid && in_ready) begin
        in_hs_cnt++;
        feed_idx++;
      end
    end
  end

  // UART receiver: samples mid-bit, abandons a frame on reset.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2) check("rx_start_bit", 32'(tx), 32'(0));
      if (rx_cnt >= CPB + CPB / 2 && rx_cnt <= 8 * CPB + CPB / 2 && (rx_cnt % CPB) == CPB / 2)
        rx_byte[(rx_cnt - CPB - CPB / 2) / CPB] = tx;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        check("rx_stop_bit", 32'(tx), 32'(1));
        tx_frames++;
        if (exp_tx_q.size() == 0) begin
          check("unexpected_tx_frame", 32'(rx_byte), 32'hFFFF_FFFF);
        end else begin
          rx_exp = exp_tx_q.pop_front();
          check("tx_byte", 32'(rx_byte), 32'(rx_exp));
        end
        rx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_out(input logic [7:0] val);
    logic [9:0] fr;
    fr = {1'b1, val, 1'b0};
    operation_in = OP_OUT; a_in = val; drdy_in = 1'b1; ack_in = 1'b1;
    tick();
    drdy_in = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      check("out_tx_bit", 32'(tx), 32'(fr[c / CPB]));
      check("out_ack_low", 32'(ack), 32'(0));
      check("out_drdy_low", 32'(drdy), 32'(0));
      tick();
    end
    check("out_idle_after_stop", 32'(tx), 32'(1));
    check("out_drdy_not_yet", 32'(drdy), 32'(0));
    tick();
    check("out_drdy_rise", 32'(drdy), 32'(1));
    check("out_a_kept", 32'(a), 32'(val));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] exp_in_latency;
    rst = 1'b1; drdy_in = 1'b0; operation_in = OP_NOP; a_in = 8'h00;
    ack_in = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    in_bytes[0] = 8'h3C;
    for (int i = 1; i < 256; i++) in_bytes[i] = 8'($urandom);

    // Reset state
    #13;
    check("rst_drdy", 32'(drdy), 32'(0));
    check("rst_op", 32'(operation), 32'(OP_NOP));
    check("rst_a", 32'(a), 32'(0));
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_ack", 32'(ack), 32'(1));
    tick();
    rst = 1'b0;
    tick();

    // Pass-through, latency 1
    operation_in = OP_INC; a_in = 8'h05; drdy_in = 1'b1; ack_in = 1'b1;
    check("pt_drdy_before", 32'(drdy), 32'(0));
    tick();
    drdy_in = 1'b0;
    check("pt_drdy", 32'(drdy), 32'(1));
    check("pt_a", 32'(a), 32'h05);
    check("pt_op", 32'(operation), 32'(OP_INC));
    check("pt_tx", 32'(tx), 32'(1));
    tick();
    check("pt_drained", 32'(drdy), 32'(0));
    check("pt_empty_op", 32'(operation), 32'(OP_NOP));

    // OUT A5
    do_out(8'hA5);

    // IN with a 20-cycle wait
    operation_in = OP_IN; a_in = 8'hFF; drdy_in = 1'b1;
    tick();
    drdy_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("in_wait_ready", 32'(in_ready), 32'(1));
      check("in_wait_drdy", 32'(drdy), 32'(0));
      tick();
    end
    in_data = 8'h3C; in_valid = 1'b1;
    check("in_ready_at_hs", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check("in_ready_after_hs", 32'(in_ready), 32'(0));
`ifdef BF_IO_ECHO_EN
    exp_in_latency = 8'd41;
`else
    exp_in_latency = 8'd0;
`endif
    n = 0;
    while (!drdy && n < 500) begin
      tick();
      n++;
    end
    check("in_latency", 32'(n), 32'(exp_in_latency));
    check("in_a", 32'(a), 32'h3C);
    check("in_handshakes", 32'(in_hs_cnt), 32'(1));
    tick();

    // Backpressure with a queued op accepted on release
    ack_in = 1'b0; operation_in = OP_INC; a_in = 8'h11; drdy_in = 1'b1;
    tick();
    operation_in = OP_DEC; a_in = 8'h22;
    for (int c = 0; c < 10; c++) begin
      check("bp_ack", 32'(ack), 32'(0));
      check("bp_a", 32'(a), 32'h11);
      check("bp_op", 32'(operation), 32'(OP_INC));
      tick();
    end
    ack_in = 1'b1;
    #1;
    check("bp_ack_release", 32'(ack), 32'(1));
    tick();
    drdy_in = 1'b0;
    check("bp_no_bubble", 32'(drdy), 32'(1));
    check("bp_next_a", 32'(a), 32'h22);
    check("bp_next_op", 32'(operation), 32'(OP_DEC));
    tick();

    // Reset in the middle of a frame (data bit 3 / frame bit 4)
    operation_in = OP_OUT; a_in = 8'h5A; drdy_in = 1'b1;
    tick();
    drdy_in = 1'b0;
    repeat (17) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'(1));
    check("mid_rst_drdy", 32'(drdy), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(0));
    check("mid_rst_a", 32'(a), 32'(0));
    exp_q.delete();
    exp_tx_q.delete();
    tick();
    rst = 1'b0;
    tick();
    do_out(8'hC3);
`ifdef BF_IO_ECHO_EN
    check("directed_frames", 32'(tx_frames), 32'(3));
`else
    check("directed_frames", 32'(tx_frames), 32'(2));
`endif

    // Randomized run against the model
    begin
      int sent, cyc, last_up, r;
      logic pending;
      sent = 0; cyc = 0; pending = 1'b0; last_up = up_cnt;
      while (sent < 300 && cyc < 30000) begin
        if (pending && up_cnt != last_up) begin
          pending = 1'b0;
          sent++;
          last_up = up_cnt;
        end
        if (!pending && $urandom_range(0, 3) != 0) begin
          r = $urandom_range(0, 9);
          if (r == 0) operation_in = OP_OUT;
          else if (r == 1) operation_in = OP_IN;
          else begin
            r = $urandom_range(0, 6);
            operation_in = (r < 5) ? 4'(r) : 4'(r + 2);
          end
          a_in = 8'($urandom);
          pending = 1'b1;
        end
        drdy_in = pending;
        ack_in = ($urandom_range(0, 9) < 7);
        in_valid = 1'($urandom_range(0, 1));
        in_data = in_bytes[feed_idx % 256];
        tick();
        cyc++;
      end
      check("random_ops_sent", 32'(sent), 32'(300));
      drdy_in = 1'b0; ack_in = 1'b1; in_valid = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || exp_tx_q.size() != 0) && n < 2000) begin
        in_data = in_bytes[feed_idx % 256];
        tick();
        n++;
      end
      in_valid = 1'b0;
      check("drain_in_time", 32'(n < 2000), 32'(1));
      check("exp_q_empty", 32'(exp_q.size()), 32'(0));
      check("exp_tx_q_empty", 32'(exp_tx_q.size()), 32'(0));
      check("in_handshake_total", 32'(in_hs_cnt), 32'(model_in_idx));
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout actual=expired required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
